// File: rtl/keypad_scanner.sv
// keypad_scanner
// ---------------------------------------------------------------------------
// Front end of the digital lock. It drives a 4x4 key matrix one column at a
// time, passes the row returns through a two-flop synchronizer and debounces
// them. Each debounced key-down produces exactly one single-cycle BPRESS
// with the key code on BUTTON.
//
// Parameters
//   SCAN_DIV        clock cycles each column is driven (3..65535)
//   DEBOUNCE_SCANS  consecutive matching samples needed to accept a press,
//                   and again to accept a release (1..15)
//
// Ports
//   CLK        in   system clock, rising edge
//   RST        in   synchronous reset, active low
//   ROW[3:0]   in   raw row returns (asynchronous), 1 = key closed
//   COL[3:0]   out  one-hot column drive, registered
//   BUTTON[3:0] out key code of the last accepted press, held between presses
//   BPRESS     out  one-cycle pulse; BUTTON is valid in the same cycle
//   BUSY       out  1 while a key is being debounced or held
//   DBG_STATE[1:0] out  press FSM state (0 idle, 1 debounce, 2 held)
//
// Handshake: BUTTON/BPRESS is a valid-only stream. BPRESS is the valid; there
// is no ready, so the consumer must take BUTTON in the cycle BPRESS is high.
// ---------------------------------------------------------------------------
module keypad_scanner #(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] ROW,
    output logic [3:0] COL,
    output logic [3:0] BUTTON,
    output logic       BPRESS,
    output logic       BUSY,
    output logic [1:0] DBG_STATE
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DEBOUNCE = 2'd1,
        S_HELD     = 2'd2
    } state_e;

    localparam logic [15:0] DWELL_LAST = 16'(SCAN_DIV - 1);
    localparam logic [3:0]  MATCH_N    = 4'(DEBOUNCE_SCANS);

    logic [3:0]  row_meta_q, row_sync_q;
    logic [15:0] dwell_q, dwell_d;
    logic [1:0]  col_idx_q, col_idx_d;
    logic [3:0]  col_q, col_d;
    state_e      state_q, state_d;
    logic [3:0]  cand_q, cand_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  button_q, button_d;
    logic        bpress_q, bpress_d;

    logic        sample;
    logic        row_any;
    logic [1:0]  row_lo;
    logic [3:0]  code;
    logic        cand_col_hit;
    logic        cand_row_set;
    logic [3:0]  cnt_inc;

    // Scan: the sample cycle is the last dwell cycle of a column, and the
    // column advances on that same edge, so the new COL shows up one cycle
    // after the sample.
    always_comb begin
        dwell_d   = dwell_q + 16'd1;
        col_idx_d = col_idx_q;
        col_d     = col_q;
        sample    = (dwell_q == DWELL_LAST);
        if (sample) begin
            dwell_d   = 16'd0;
            col_idx_d = col_idx_q + 2'd1;
            col_d     = 4'b0001 << col_idx_d;
        end
    end

    // Encoder: lowest closed row wins.
    always_comb begin
        row_any = |row_sync_q;
        row_lo  = 2'd0;
        if (row_sync_q[0])      row_lo = 2'd0;
        else if (row_sync_q[1]) row_lo = 2'd1;
        else if (row_sync_q[2]) row_lo = 2'd2;
        else if (row_sync_q[3]) row_lo = 2'd3;
        code = {col_idx_q, row_lo};
    end

    assign cand_col_hit = (col_idx_q == cand_q[3:2]);
    assign cand_row_set = row_sync_q[cand_q[1:0]];
    assign cnt_inc      = cnt_q + 4'd1;

    // Press FSM; only sample cycles can change state.
    always_comb begin
        state_d  = state_q;
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        button_d = button_q;
        bpress_d = 1'b0;
        if (sample) begin
            case (state_q)
                S_IDLE: begin
                    if (row_any) begin
                        cand_d = code;
                        if (DEBOUNCE_SCANS == 1) begin
                            button_d = code;
                            bpress_d = 1'b1;
                            cnt_d    = 4'd0;
                            state_d  = S_HELD;
                        end else begin
                            cnt_d   = 4'd1;
                            state_d = S_DEBOUNCE;
                        end
                    end
                end
                S_DEBOUNCE: begin
                    // Samples of other columns say nothing about the candidate.
                    if (cand_col_hit) begin
                        if (!cand_row_set) begin
                            cnt_d   = 4'd0;
                            state_d = S_IDLE;
                        end else if (cnt_inc == MATCH_N) begin
                            button_d = cand_q;
                            bpress_d = 1'b1;
                            cnt_d    = 4'd0;
                            state_d  = S_HELD;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end
                end
                S_HELD: begin
                    // No rollover: only the held key's position is watched.
                    if (cand_col_hit) begin
                        if (cand_row_set) begin
                            cnt_d = 4'd0;
                        end else if (cnt_inc == MATCH_N) begin
                            cnt_d   = 4'd0;
                            state_d = S_IDLE;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end
                end
                default: begin
                    cnt_d   = 4'd0;
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            row_meta_q <= 4'd0;
            row_sync_q <= 4'd0;
            dwell_q    <= 16'd0;
            col_idx_q  <= 2'd0;
            col_q      <= 4'b0001;
            state_q    <= S_IDLE;
            cand_q     <= 4'd0;
            cnt_q      <= 4'd0;
            button_q   <= 4'd0;
            bpress_q   <= 1'b0;
        end else begin
            row_meta_q <= ROW;
            row_sync_q <= row_meta_q;
            dwell_q    <= dwell_d;
            col_idx_q  <= col_idx_d;
            col_q      <= col_d;
            state_q    <= state_d;
            cand_q     <= cand_d;
            cnt_q      <= cnt_d;
            button_q   <= button_d;
            bpress_q   <= bpress_d;
        end
    end

    assign COL       = col_q;
    assign BUTTON    = button_q;
    assign BPRESS    = bpress_q;
    assign BUSY      = (state_q != S_IDLE);
    assign DBG_STATE = state_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner with SCAN_DIV = 4, DEBOUNCE_SCANS = 3.
// A small key-matrix model turns the set of closed keys into ROW for the
// currently driven column.
module tb_keypad_scanner;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [3:0] ROW;
    logic [3:0] COL;
    logic [3:0] BUTTON;
    logic       BPRESS;
    logic       BUSY;
    logic [1:0] DBG_STATE;

    logic [15:0] keys      = 16'd0;
    logic        use_force = 1'b1;
    logic [3:0]  row_force = 4'hF;
    logic [3:0]  row_drv;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int pulse_cnt = 0;
    int last_btn  = 0;
    int last_pulse_cyc = 0;
    logic prev_bp = 1'b0;

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3)) dut (
        .CLK(CLK), .RST(RST), .ROW(ROW), .COL(COL), .BUTTON(BUTTON),
        .BPRESS(BPRESS), .BUSY(BUSY), .DBG_STATE(DBG_STATE)
    );

    // ---------------- clock / reset ----------------
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- key matrix model ----------------
    always_comb begin
        row_drv = 4'd0;
        for (int c = 0; c < 4; c++)
            if (COL[c]) row_drv = row_drv | keys[4*c +: 4];
        ROW = use_force ? row_force : row_drv;
    end

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Every BPRESS is recorded; a pulse longer than one cycle is an error.
    always @(negedge CLK) begin
        if (BPRESS) begin
            pulse_cnt++;
            last_btn       = int'(BUTTON);
            last_pulse_cyc = cyc;
            check("bpress_single_cycle", int'(prev_bp), 0);
        end
        prev_bp = BPRESS;
    end

    // ---------------- driver tasks ----------------
    // Returns just after COL switches to column c; keys changed now are seen
    // by that column's coming sample.
    task automatic at_col_start(input int c);
        logic [3:0] prev;
        logic [3:0] want;
        bit found;
        found = 1'b0;
        want  = 4'(1 << c);
        for (int i = 0; i < 40 && !found; i++) begin
            prev = COL;
            @(posedge CLK); #1;
            if (COL == want && prev != want) found = 1'b1;
        end
        if (!found) begin
            n_checks++;
            $display("FAIL col_start_timeout: got col %b expected %b", COL, want);
        end
    endtask

    task automatic idle_wait();
        keys = 16'd0;
        repeat (64) @(posedge CLK);
        #1;
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        logic [15:0] keys;
        int          exp_btn;
        int          exp_pulses;
        int          max_lat;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int p0, t0, r0;

        vecs[0] = '{16'h0040,  6, 1, 67};  // key 6: col 1 row 2
        vecs[1] = '{16'h000A,  1, 1, 67};  // rows 1 and 3 of col 0: lowest wins
        vecs[2] = '{16'h0001,  0, 1, 67};  // key 0
        vecs[3] = '{16'h8000, 15, 1, 67};  // key 15
        vecs[4] = '{16'h0100,  8, 1, 67};  // key 8 (Enter)
        vecs[5] = '{16'h1000, 12, 1, 67};  // key 12
        vecs[6] = '{16'hF000, 12, 1, 67};  // whole col 3 closed
        vecs[7] = '{16'h0C00, 10, 1, 67};  // rows 2,3 of col 2

        // ---- reset with all rows high ----
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            check("rst_col", int'(COL), 1);
            check("rst_button", int'(BUTTON), 0);
            check("rst_bpress", int'(BPRESS), 0);
            check("rst_busy", int'(BUSY), 0);
        end
        check("rst_state", int'(DBG_STATE), 0);
        @(negedge CLK);
        RST = 1'b1;
        use_force = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            @(posedge CLK); #1;
            check("scan_col", int'(COL), 1 << ((k / 4) % 4));
        end

        // ---- table-driven presses ----
        for (int i = 0; i < 8; i++) begin
            idle_wait();
            check("vec_idle_busy", int'(BUSY), 0);
            p0 = pulse_cnt;
            keys = vecs[i].keys;
            t0 = cyc;
            repeat (200) @(posedge CLK);
            #1;
            check("vec_pulses", pulse_cnt - p0, vecs[i].exp_pulses);
            check("vec_button", last_btn, vecs[i].exp_btn);
            check("vec_latency_ok",
                  int'(pulse_cnt > p0 && (last_pulse_cyc - t0) <= vecs[i].max_lat), 1);
            check("vec_busy_held", int'(BUSY), 1);
            keys = 16'd0;
            repeat (30) @(posedge CLK);
            #1;
            check("vec_busy_release_pending", int'(BUSY), 1);
            repeat (40) @(posedge CLK);
            #1;
            check("vec_busy_released", int'(BUSY), 0);
            check("vec_button_held", int'(BUTTON), vecs[i].exp_btn);
        end

        // ---- bounce on key 8 ----
        idle_wait();
        p0 = pulse_cnt;
        at_col_start(2);
        keys = 16'h0100;
        at_col_start(2);
        at_col_start(2);
        check("bounce_busy_2match", int'(BUSY), 1);
        keys = 16'd0;
        at_col_start(2);
        check("bounce_aborted", int'(BUSY), 0);
        check("bounce_no_pulse", pulse_cnt - p0, 0);
        keys = 16'h0100;
        at_col_start(2);
        at_col_start(2);
        check("bounce_pending", pulse_cnt - p0, 0);
        at_col_start(2);
        check("bounce_pulse", pulse_cnt - p0, 1);
        check("bounce_button", last_btn, 8);

        // ---- multi-key and no rollover ----
        idle_wait();
        p0 = pulse_cnt;
        keys = 16'h000A;
        repeat (80) @(posedge CLK);
        #1;
        check("multi_pulse", pulse_cnt - p0, 1);
        check("multi_button", last_btn, 1);
        keys = 16'h800A;
        repeat (100) @(posedge CLK);
        #1;
        check("rollover_no_pulse", pulse_cnt - p0, 1);
        check("rollover_busy", int'(BUSY), 1);
        check("rollover_button", int'(BUTTON), 1);
        keys = 16'h8000;
        repeat (150) @(posedge CLK);
        #1;
        check("rollover_second_pulse", pulse_cnt - p0, 2);
        check("rollover_button15", last_btn, 15);

        // ---- reset mid-debounce on key 5 ----
        idle_wait();
        p0 = pulse_cnt;
        at_col_start(1);
        keys = 16'h0020;
        at_col_start(1);
        at_col_start(1);
        check("mid_rst_debouncing", int'(DBG_STATE), 1);
        @(negedge CLK);
        RST = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            check("mid_rst_bpress", int'(BPRESS), 0);
        end
        check("mid_rst_state", int'(DBG_STATE), 0);
        check("mid_rst_busy", int'(BUSY), 0);
        check("mid_rst_col", int'(COL), 1);
        RST = 1'b1;
        r0 = cyc;
        @(negedge CLK);
        check("mid_rst_bpress_after", int'(BPRESS), 0);
        repeat (80) @(posedge CLK);
        #1;
        check("mid_rst_pulse", pulse_cnt - p0, 1);
        check("mid_rst_button", last_btn, 5);
        check("mid_rst_fresh_latency",
              int'((last_pulse_cyc - r0) >= 36 && (last_pulse_cyc - r0) <= 44), 1);

        // ---- release glitch on key 3 ----
        idle_wait();
        p0 = pulse_cnt;
        at_col_start(0);
        keys = 16'h0008;
        at_col_start(0);
        at_col_start(0);
        at_col_start(0);
        check("glitch_press_pulse", pulse_cnt - p0, 1);
        check("glitch_press_button", last_btn, 3);
        keys = 16'd0;
        at_col_start(0);
        at_col_start(0);
        check("glitch_busy_2open", int'(BUSY), 1);
        keys = 16'h0008;
        at_col_start(0);
        check("glitch_busy_reclose", int'(BUSY), 1);
        keys = 16'd0;
        at_col_start(0);
        at_col_start(0);
        check("glitch_busy_2final", int'(BUSY), 1);
        at_col_start(0);
        check("glitch_idle_busy", int'(BUSY), 0);
        check("glitch_idle_state", int'(DBG_STATE), 0);
        check("glitch_no_release_pulse", pulse_cnt - p0, 1);
        keys = 16'h0008;
        repeat (80) @(posedge CLK);
        #1;
        check("glitch_repress_pulse", pulse_cnt - p0, 2);
        check("glitch_repress_button", last_btn, 3);
        keys = 16'd0;

        // ---- report ----
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
